// File: rtl/panel_pkg.sv
// panel_pkg: function-select and controller-state types plus default panel timing constants
package panel_pkg;
  typedef enum logic [1:0] {SEL_CLOCK = 2'd0, SEL_STOPWATCH = 2'd1, SEL_TIMER = 2'd2} sel_t;
  typedef enum logic {NORMAL, ALARM} ctrl_state_t;
  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_REPEAT_DELAY  = 50;
  localparam int DEF_REPEAT_RATE   = 10;
  localparam int DEF_ALARM_HALF    = 25;
  localparam int DEF_ALARM_TIMEOUT = 3000;
endpackage

// File: rtl/mode_ctrl_btn_sync_edge.sv
// btn_sync_edge: synchronise raw button btn (clk, reset_n) into synced level and one-cycle rise pulse
module btn_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn,
  output logic level,
  output logic rise
);
  logic [SYNC_STAGES-1:0] sync;
  logic prev;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= SYNC_STAGES'({sync, btn});
      prev <= sync[SYNC_STAGES-1];
    end
  end
  assign level = sync[SYNC_STAGES-1];
  assign rise  = level & ~prev;
endmodule

// File: rtl/mode_ctrl.sv
// mode_ctrl: panel controller; buttons in -> sel, inc/dec/state/start pulses, alarm, alarm_active, disp_* out
module mode_ctrl
  import panel_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE   = DEF_REPEAT_RATE,
  parameter int ALARM_HALF    = DEF_ALARM_HALF,
  parameter int ALARM_TIMEOUT = DEF_ALARM_TIMEOUT
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_dec,
  input  logic       btn_state,
  input  logic       btn_start,
  input  logic       timer_done,
  input  logic [5:0] clk_h,
  input  logic [5:0] clk_m,
  input  logic [5:0] clk_s,
  input  logic [5:0] sw_h,
  input  logic [5:0] sw_m,
  input  logic [5:0] sw_s,
  input  logic [5:0] tmr_h,
  input  logic [5:0] tmr_m,
  input  logic [5:0] tmr_s,
  output logic [1:0] sel,
  output logic       inc,
  output logic       dec,
  output logic       state,
  output logic       start,
  output logic [5:0] disp_h,
  output logic [5:0] disp_m,
  output logic [5:0] disp_s,
  output logic       alarm,
  output logic       alarm_active
);
  localparam int RW = $clog2(REPEAT_DELAY);
  localparam int HW = $clog2(ALARM_HALF);
  localparam int TW = $clog2(ALARM_TIMEOUT);
  logic [4:0] raw, lvl, rise;
  logic [RW-1:0] rpt_cnt;
  logic [HW-1:0] h_cnt;
  logic [TW-1:0] t_cnt;
  ctrl_state_t st;
  logic td_prev, td_rise, one, rpt_hit, inc_go, dec_go, h_hit, t_hit, unused_lvl;
  assign raw = {btn_start, btn_state, btn_dec, btn_inc, btn_mode};
  for (genvar i = 0; i < 5; i++) begin : g_btn
    btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_btn (
      .clk,
      .reset_n,
      .btn(raw[i]),
      .level(lvl[i]),
      .rise(rise[i])
    );
  end
  assign unused_lvl = ^{lvl[4:3], lvl[0]};
  assign td_rise = timer_done & ~td_prev;
  // repeat runs only while exactly one of inc/dec is held
  assign one     = lvl[1] ^ lvl[2];
  assign rpt_hit = one && rpt_cnt == RW'(REPEAT_DELAY - 1);
  assign inc_go  = (rise[1] & ~lvl[2]) | (rpt_hit & lvl[1]);
  assign dec_go  = (rise[2] & ~lvl[1]) | (rpt_hit & lvl[2]);
  assign h_hit   = h_cnt == HW'(ALARM_HALF - 1);
  assign t_hit   = t_cnt == TW'(ALARM_TIMEOUT - 1);
  assign alarm_active = st == ALARM;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st      <= NORMAL;
      sel     <= 2'd0;
      inc     <= 1'b0;
      dec     <= 1'b0;
      state   <= 1'b0;
      start   <= 1'b0;
      alarm   <= 1'b0;
      rpt_cnt <= '0;
      h_cnt   <= '0;
      t_cnt   <= '0;
      td_prev <= 1'b0;
    end else begin
      td_prev <= timer_done;
      inc     <= 1'b0;
      dec     <= 1'b0;
      state   <= 1'b0;
      start   <= 1'b0;
      if (st == NORMAL) begin
        if (td_rise) begin
          st      <= ALARM;
          sel     <= SEL_TIMER;
          alarm   <= 1'b1;
          rpt_cnt <= '0;
          h_cnt   <= '0;
          t_cnt   <= '0;
        end else begin
          // after the first repeat pulse, jump back so later pulses come every REPEAT_RATE
          rpt_cnt <= (one && !rise[1] && !rise[2])
                     ? (rpt_hit ? RW'(REPEAT_DELAY - REPEAT_RATE) : rpt_cnt + RW'(1)) : '0;
          if (rise[0]) begin
            sel <= (sel == SEL_TIMER) ? 2'd0 : sel + 2'd1;
          end else begin
            inc   <= inc_go;
            dec   <= dec_go;
            state <= rise[3];
            start <= rise[4];
          end
        end
      end else begin
        rpt_cnt <= '0;
        if (rise[3] || t_hit) begin
          st    <= NORMAL;
          state <= 1'b1;
          alarm <= 1'b0;
          h_cnt <= '0;
          t_cnt <= '0;
        end else begin
          h_cnt <= h_hit ? '0 : h_cnt + HW'(1);
          alarm <= alarm ^ h_hit;
          t_cnt <= t_cnt + TW'(1);
        end
      end
    end
  end
  assign disp_h = sel == SEL_CLOCK ? clk_h : sel == SEL_STOPWATCH ? sw_h : sel == SEL_TIMER ? tmr_h : 6'd0;
  assign disp_m = sel == SEL_CLOCK ? clk_m : sel == SEL_STOPWATCH ? sw_m : sel == SEL_TIMER ? tmr_m : 6'd0;
  assign disp_s = sel == SEL_CLOCK ? clk_s : sel == SEL_STOPWATCH ? sw_s : sel == SEL_TIMER ? tmr_s : 6'd0;
endmodule

// File: tb/tb_mode_ctrl.sv
// tb_mode_ctrl: scoreboard bench for mode_ctrl pulses, select, alarm and display
module tb_mode_ctrl;
  localparam logic [5:0] CH = 6'd11, CM = 6'd22, CS = 6'd33;
  localparam logic [5:0] SH = 6'd1,  SM = 6'd2,  SS = 6'd3;
  localparam logic [5:0] TH = 6'd44, TM = 6'd55, TS = 6'd59;
  logic clk = 1'b0, reset_n = 1'b0;
  logic btn_mode = 1'b0, btn_inc = 1'b0, btn_dec = 1'b0, btn_state = 1'b0, btn_start = 1'b0;
  logic timer_done = 1'b0;
  logic [1:0] sel;
  logic inc, dec, state, start, alarm, alarm_active;
  logic [5:0] disp_h, disp_m, disp_s;
  logic [3:0] pulses;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  typedef struct {
    int cyc;
    logic [3:0] p;
  } exp_t;
  exp_t exp_q[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign pulses = {inc, dec, state, start};
  mode_ctrl dut (
    .clk(clk), .reset_n(reset_n),
    .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec),
    .btn_state(btn_state), .btn_start(btn_start), .timer_done(timer_done),
    .clk_h(CH), .clk_m(CM), .clk_s(CS),
    .sw_h(SH), .sw_m(SM), .sw_s(SS),
    .tmr_h(TH), .tmr_m(TM), .tmr_s(TS),
    .sel(sel), .inc(inc), .dec(dec), .state(state), .start(start),
    .disp_h(disp_h), .disp_m(disp_m), .disp_s(disp_s),
    .alarm(alarm), .alarm_active(alarm_active)
  );
  task automatic push_exp(input int c, input logic [3:0] p);
    exp_t e;
    e.cyc = c;
    e.p = p;
    exp_q.push_back(e);
  endtask
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (pulses !== 4'b0) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL pulse_unexpected: cyc=%0d got=%b required none", cyc, pulses);
        end else begin
          e = exp_q.pop_front();
          if (e.cyc != cyc || e.p !== pulses) begin
            errors++;
            $display("FAIL pulse_match: got cyc=%0d pulses=%b required cyc=%0d pulses=%b", cyc, pulses, e.cyc, e.p);
          end
        end
      end
    end
  endtask
  task automatic test_reset();
    logic [1:0] seq [3];
    logic [17:0] dtab [3];
    logic [1:0] prev;
    seq = '{2'd1, 2'd2, 2'd0};
    dtab = '{{SH, SM, SS}, {TH, TM, TS}, {CH, CM, CS}};
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({sel, pulses, alarm, alarm_active} !== 8'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b required 00000000", {sel, pulses, alarm, alarm_active});
    end
    checks++;
    if ({disp_h, disp_m, disp_s} !== {CH, CM, CS}) begin
      errors++;
      $display("FAIL reset_disp: got %h required %h", {disp_h, disp_m, disp_s}, {CH, CM, CS});
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      prev = (i == 0) ? 2'd0 : seq[i-1];
      btn_mode = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (sel !== prev) begin
        errors++;
        $display("FAIL mode_early[%0d]: sel got %0d required %0d", i, sel, prev);
      end
      @(negedge clk);
      checks++;
      if (sel !== seq[i]) begin
        errors++;
        $display("FAIL mode_sel[%0d]: sel got %0d required %0d", i, sel, seq[i]);
      end
      checks++;
      if ({disp_h, disp_m, disp_s} !== dtab[i]) begin
        errors++;
        $display("FAIL mode_disp[%0d]: got %h required %h", i, {disp_h, disp_m, disp_s}, dtab[i]);
      end
      btn_mode = 1'b0;
      repeat (4) @(negedge clk);
    end
    btn_mode = 1'b1;
    repeat (4) @(negedge clk);
    btn_mode = 1'b0;
    repeat (4) @(negedge clk);
    btn_inc = 1'b1;
    push_exp(cyc + 3, 4'b1000);
    repeat (20) @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++;
    if ({sel, pulses, alarm, alarm_active} !== 8'b0) begin
      errors++;
      $display("FAIL reset_midrepeat: got %b required 00000000", {sel, pulses, alarm, alarm_active});
    end
    btn_inc = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (60) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL reset_pending: pending got %0d required 0", exp_q.size());
      exp_q.delete();
    end
  endtask
  task automatic test_autorepeat();
    int offs [6];
    int n;
    offs = '{3, 53, 63, 73, 83, 93};
    n = 0;
    @(negedge clk);
    btn_inc = 1'b1;
    foreach (offs[k]) push_exp(cyc + offs[k], 4'b1000);
    repeat (100) begin
      @(negedge clk);
      if (inc) n++;
    end
    btn_inc = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (inc) n++;
    end
    checks++;
    if (n != 6) begin
      errors++;
      $display("FAIL repeat_count: got %0d required 6", n);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL repeat_pending: pending got %0d required 0", exp_q.size());
      exp_q.delete();
    end
  endtask
  task automatic test_simultaneous();
    int n;
    n = 0;
    @(negedge clk);
    btn_inc = 1'b1;
    btn_dec = 1'b1;
    repeat (80) begin
      @(negedge clk);
      if (inc | dec) n++;
    end
    btn_inc = 1'b0;
    btn_dec = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (inc | dec) n++;
    end
    checks++;
    if (n != 0) begin
      errors++;
      $display("FAIL incdec_both: pulses got %0d required 0", n);
    end
    n = 0;
    btn_mode = 1'b1;
    btn_start = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (start) n++;
    end
    checks++;
    if (sel !== 2'd1) begin
      errors++;
      $display("FAIL mode_start_sel: sel got %0d required 1", sel);
    end
    btn_mode = 1'b0;
    btn_start = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (start) n++;
    end
    checks++;
    if (n != 0) begin
      errors++;
      $display("FAIL mode_start_drop: start pulses got %0d required 0", n);
    end
  endtask
  task automatic test_alarm_entry();
    logic [1:0] seq [2];
    int n;
    seq = '{2'd2, 2'd0};
    for (int i = 0; i < 2; i++) begin
      btn_mode = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (sel !== seq[i]) begin
        errors++;
        $display("FAIL pre_alarm_sel[%0d]: sel got %0d required %0d", i, sel, seq[i]);
      end
      btn_mode = 1'b0;
      repeat (4) @(negedge clk);
    end
    timer_done = 1'b1;
    @(negedge clk);
    checks++;
    if ({sel, alarm_active, alarm} !== 4'b1011) begin
      errors++;
      $display("FAIL alarm_entry: {sel,active,alarm} got %b required 1011", {sel, alarm_active, alarm});
    end
    repeat (24) @(negedge clk);
    checks++;
    if (alarm !== 1'b1) begin
      errors++;
      $display("FAIL alarm_half1_end: alarm got %b required 1", alarm);
    end
    @(negedge clk);
    checks++;
    if (alarm !== 1'b0) begin
      errors++;
      $display("FAIL alarm_toggle1: alarm got %b required 0", alarm);
    end
    repeat (24) @(negedge clk);
    checks++;
    if (alarm !== 1'b0) begin
      errors++;
      $display("FAIL alarm_half2_end: alarm got %b required 0", alarm);
    end
    @(negedge clk);
    checks++;
    if (alarm !== 1'b1) begin
      errors++;
      $display("FAIL alarm_toggle2: alarm got %b required 1", alarm);
    end
    n = 0;
    btn_mode = 1'b1;
    btn_inc = 1'b1;
    btn_start = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (pulses !== 4'b0) n++;
    end
    btn_mode = 1'b0;
    btn_inc = 1'b0;
    btn_start = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (pulses !== 4'b0) n++;
    end
    checks++;
    if (n != 0 || sel !== 2'd2 || alarm_active !== 1'b1) begin
      errors++;
      $display("FAIL alarm_ignore: pulses=%0d sel=%0d active=%b required 0 2 1", n, sel, alarm_active);
    end
  endtask
  task automatic test_alarm_exit();
    timer_done = 1'b0;
    @(negedge clk);
    btn_state = 1'b1;
    push_exp(cyc + 3, 4'b0010);
    repeat (2) @(negedge clk);
    checks++;
    if (alarm_active !== 1'b1) begin
      errors++;
      $display("FAIL exit_early: alarm_active got %b required 1", alarm_active);
    end
    @(negedge clk);
    checks++;
    if ({sel, alarm_active, alarm} !== 4'b1000) begin
      errors++;
      $display("FAIL exit_state: {sel,active,alarm} got %b required 1000", {sel, alarm_active, alarm});
    end
    btn_state = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL exit_pending: pending got %0d required 0", exp_q.size());
      exp_q.delete();
    end
  endtask
  task automatic test_alarm_timeout();
    @(negedge clk);
    timer_done = 1'b1;
    push_exp(cyc + 3001, 4'b0010);
    @(negedge clk);
    checks++;
    if (alarm_active !== 1'b1) begin
      errors++;
      $display("FAIL timeout_entry: alarm_active got %b required 1", alarm_active);
    end
    repeat (2999) @(negedge clk);
    checks++;
    if (alarm_active !== 1'b1) begin
      errors++;
      $display("FAIL timeout_early: alarm_active got %b required 1", alarm_active);
    end
    @(negedge clk);
    checks++;
    if ({sel, alarm_active, alarm} !== 4'b1000) begin
      errors++;
      $display("FAIL timeout_exit: {sel,active,alarm} got %b required 1000", {sel, alarm_active, alarm});
    end
    repeat (10) @(negedge clk);
    timer_done = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL timeout_pending: pending got %0d required 0", exp_q.size());
      exp_q.delete();
    end
  endtask
  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_autorepeat();
    test_simultaneous();
    test_alarm_entry();
    test_alarm_exit();
    test_alarm_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
